// File: rtl/axi4_write_data.sv
// rtl/axi4_write_data.sv - AXI4-Stream to DDR4 adapter write-data FIFO
//
// Accepts DATA_W-bit beats from an AXI4-Stream slave port and holds them in a
// DEPTH-entry FIFO. Each ddr_wr_req pulse pops one beat into ddr_wr_data, which
// is flagged fresh by ddr_wr_valid exactly one cycle after the request. A
// request that finds the FIFO empty sets the sticky err flag.
//
// Optional feature macro: AXI_WR_KEEP_CHECK_EN
//   defined   : a pushed beat whose TKEEP is not all-ones also sets err
//   undefined : TKEEP is ignored
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   S_AXIS_TDATA      stream beat data
//   S_AXIS_TKEEP      byte qualifiers (checked only with the macro)
//   S_AXIS_TVALID     stream beat valid
//   S_AXIS_TLAST      ignored
//   S_AXIS_TREADY     registered ready, high while the FIFO has room
//   ddr_wr_req        one-cycle request for one write beat
//   ddr_wr_data       beat returned for the most recent serviced request
//   ddr_wr_valid      ddr_wr_data is fresh this cycle
//   fifo_count        beats stored, 0..DEPTH
//   err               sticky error flag
//   latest_buf        ddr_wr_data[15:0]

module axi4_write_data #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
  input  logic                S_AXIS_TVALID,
  input  logic                S_AXIS_TLAST,
  output logic                S_AXIS_TREADY,
  input  logic                ddr_wr_req,
  output logic [DATA_W-1:0]   ddr_wr_data,
  output logic                ddr_wr_valid,
  output logic [PTR_W:0]      fifo_count,
  output logic                err,
  output logic [15:0]         latest_buf
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              tready_q, tready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic push;
  logic pop;
  logic underflow;
  logic keep_err;

  // TLAST carries no information here (the DMA marks every beat last).
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;

`ifdef AXI_WR_KEEP_CHECK_EN
  assign keep_err = push && (S_AXIS_TKEEP != '1);
`else
  logic unused_tkeep;
  assign unused_tkeep = ^S_AXIS_TKEEP;
  assign keep_err     = 1'b0;
`endif

  always_comb begin
    // Pop and underflow look only at the count before this edge, so a beat
    // arriving at the same edge cannot satisfy the request (no bypass).
    push      = S_AXIS_TVALID && tready_q;
    pop       = ddr_wr_req && (count_q != '0);
    underflow = ddr_wr_req && (count_q == '0);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = S_AXIS_TDATA;
    end

    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    // Ready is registered from the next count so it is free of input paths.
    tready_d  = count_d < DEPTH_C;
    rd_data_d = pop ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop;
    err_d     = err_q | underflow | keep_err;
  end

  // Storage contents need no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tready_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tready_q   <= tready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign ddr_wr_data   = rd_data_q;
  assign ddr_wr_valid  = rd_valid_q;
  assign fifo_count    = count_q;
  assign err           = err_q;
  assign latest_buf    = rd_data_q[15:0];

endmodule

// File: tb/tb_axi4_write_data.sv
// tb/tb_axi4_write_data.sv - directed self-checking bench for axi4_write_data

module tb_axi4_write_data;

  localparam int DATA_W = 512;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic                clk;
  logic                rst_n;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;
  logic                req;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_valid;
  logic [PTR_W:0]      fifo_count;
  logic                err;
  logic [15:0]         latest_buf;

  int checks = 0;
  int fails  = 0;
  logic exp_keep_err;

  axi4_write_data #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TKEEP  (tkeep),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TREADY (tready),
    .ddr_wr_req    (req),
    .ddr_wr_data   (wr_data),
    .ddr_wr_valid  (wr_valid),
    .fifo_count    (fifo_count),
    .err           (err),
    .latest_buf    (latest_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tvalid = 1'b0; req = 1'b0; tdata = '0; tkeep = '1; tlast = 1'b0;
    tick(); tick();
    checks++; if (tready !== 1'b0) begin fails++; $display("FAIL rst_tready got %0b want 0", tready); end
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", wr_valid); end
    checks++; if (wr_data !== '0) begin fails++; $display("FAIL rst_data got %0h want 0", wr_data); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %0b want 0", err); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    checks++; if (latest_buf !== 16'h0) begin fails++; $display("FAIL rst_latest got %0h want 0", latest_buf); end
    rst_n = 1'b1;
    tick();
    checks++; if (tready !== 1'b1) begin fails++; $display("FAIL rel_tready got %0b want 1", tready); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rel_count got %0d want 0", fifo_count); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL rel_err got %0b want 0", err); end
  endtask

  task automatic test_single();
    tdata = {64{8'hA5}}; tvalid = 1'b1; tlast = 1'b1;
    tick();
    tvalid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count got %0d want 1", fifo_count); end
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid got %0b want 0", wr_valid); end
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    checks++; if (wr_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b want 1", wr_valid); end
    checks++; if (wr_data !== {64{8'hA5}}) begin fails++; $display("FAIL single_data got %0h want a5..a5", wr_data); end
    checks++; if (latest_buf !== 16'hA5A5) begin fails++; $display("FAIL single_latest got %0h want a5a5", latest_buf); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_count0 got %0d want 0", fifo_count); end
    tick();
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop got %0b want 0", wr_valid); end
    checks++; if (wr_data !== {64{8'hA5}}) begin fails++; $display("FAIL single_hold got %0h want a5..a5", wr_data); end
  endtask

  task automatic test_back_to_back();
    tlast = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tdata = DATA_W'(i); tvalid = 1'b1;
      tick();
      if (i == 4) begin
        checks++; if (tready !== 1'b0) begin fails++; $display("FAIL full_tready got %0b want 0", tready); end
      end
    end
    tvalid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", fifo_count); end
    checks++; if (tready !== 1'b0) begin fails++; $display("FAIL full_tready_hold got %0b want 0", tready); end
    for (int i = 1; i <= 4; i++) begin
      req = 1'b1;
      tick();
      checks++; if (wr_valid !== 1'b1 || wr_data !== DATA_W'(i)) begin fails++; $display("FAIL drain_%0d got v=%0b d=%0h want v=1 d=%0h", i, wr_valid, wr_data, i); end
      if (i == 1) begin
        checks++; if (tready !== 1'b1) begin fails++; $display("FAIL unfull_tready got %0b want 1", tready); end
      end
    end
    req = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL drain_count got %0d want 0", fifo_count); end
    for (int i = 5; i <= 6; i++) begin
      tdata = DATA_W'(i); tvalid = 1'b1;
      tick();
    end
    tvalid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL wrap_count got %0d want 2", fifo_count); end
    for (int i = 5; i <= 6; i++) begin
      req = 1'b1;
      tick();
      checks++; if (wr_valid !== 1'b1 || wr_data !== DATA_W'(i)) begin fails++; $display("FAIL wrap_%0d got v=%0b d=%0h want v=1 d=%0h", i, wr_valid, wr_data, i); end
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    tdata = DATA_W'(32'h10); tvalid = 1'b1; tick();
    tdata = DATA_W'(32'h11); tick();
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL simul_pre got %0d want 2", fifo_count); end
    tdata = DATA_W'(32'h12); req = 1'b1;
    tick();
    tvalid = 1'b0; req = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL simul_count got %0d want 2", fifo_count); end
    checks++; if (wr_valid !== 1'b1 || wr_data !== DATA_W'(32'h10)) begin fails++; $display("FAIL simul_data got v=%0b d=%0h want v=1 d=10", wr_valid, wr_data); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL simul_err got %0b want 0", err); end
    req = 1'b1;
    tick();
    checks++; if (wr_data !== DATA_W'(32'h11)) begin fails++; $display("FAIL simul_d11 got %0h want 11", wr_data); end
    tick();
    req = 1'b0;
    checks++; if (wr_data !== DATA_W'(32'h12)) begin fails++; $display("FAIL simul_d12 got %0h want 12", wr_data); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL simul_empty got %0d want 0", fifo_count); end
  endtask

  task automatic test_underflow();
    req = 1'b1; tvalid = 1'b1; tdata = DATA_W'(32'h77);
    tick();
    req = 1'b0; tvalid = 1'b0;
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL uf_err got %0b want 1", err); end
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL uf_valid got %0b want 0", wr_valid); end
    checks++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL uf_count got %0d want 1", fifo_count); end
    checks++; if (wr_data !== DATA_W'(32'h12)) begin fails++; $display("FAIL uf_data_hold got %0h want 12", wr_data); end
    tick();
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL uf_sticky got %0b want 1", err); end
    req = 1'b1;
    tick();
    req = 1'b0;
    checks++; if (wr_valid !== 1'b1 || wr_data !== DATA_W'(32'h77)) begin fails++; $display("FAIL uf_next got v=%0b d=%0h want v=1 d=77", wr_valid, wr_data); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL uf_sticky2 got %0b want 1", err); end
  endtask

  task automatic test_reset_mid();
    tdata = DATA_W'(32'h55); tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL mid_count got %0d want 0", fifo_count); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL mid_err got %0b want 0", err); end
    checks++; if (tready !== 1'b0 || wr_data !== '0) begin fails++; $display("FAIL mid_out got r=%0b d=%0h want r=0 d=0", tready, wr_data); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (tready !== 1'b1) begin fails++; $display("FAIL mid_rel got %0b want 1", tready); end
  endtask

  task automatic test_keep();
`ifdef AXI_WR_KEEP_CHECK_EN
    exp_keep_err = 1'b1;
`else
    exp_keep_err = 1'b0;
`endif
    tdata = {64{8'h3C}}; tkeep = {{56{1'b1}}, 8'hFE}; tvalid = 1'b1;
    tick();
    tvalid = 1'b0; tkeep = '1;
    checks++; if (err !== exp_keep_err) begin fails++; $display("FAIL keep_err got %0b want %0b", err, exp_keep_err); end
    req = 1'b1;
    tick();
    req = 1'b0;
    checks++; if (wr_valid !== 1'b1 || wr_data !== {64{8'h3C}}) begin fails++; $display("FAIL keep_data got v=%0b d=%0h want v=1 d=3c..3c", wr_valid, wr_data); end
    checks++; if (err !== exp_keep_err) begin fails++; $display("FAIL keep_sticky got %0b want %0b", err, exp_keep_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_underflow();
    test_reset_mid();
    test_keep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
